// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store sequencer.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] WHB_BYTE = 2'b00;
  localparam logic [1:0] WHB_HALF = 2'b01;
  localparam logic [1:0] WHB_WORD = 2'b10;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // True when the access width is legal and naturally aligned at this address.
  function automatic logic whb_aligned(input logic [1:0] whb, input logic [1:0] addr_lo);
    logic ok;
    case (whb)
      WHB_BYTE: ok = 1'b1;
      WHB_HALF: ok = ~addr_lo[0];
      WHB_WORD: ok = (addr_lo == 2'b00);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory request/grant/response port between the LSU and memory.
// Handshake: the master raises mem_req with stable mem_we/addr/be/wdata and holds
// them until a cycle where mem_gnt=1; read data returns later as a one-cycle mem_rvalid.
interface lsu_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction / sign extension for loads.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_st_whb,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [1:0]  i_ld_whb,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic        i_ld_su,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be    = BE_WORD;
    o_wdata = i_st_data;
    case (i_st_whb)
      WHB_BYTE: begin
        o_be    = BE_BYTE0 << i_st_addr_lo;
        o_wdata = {4{i_st_data[7:0]}};
      end
      WHB_HALF: begin
        o_be    = i_st_addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        o_wdata = {2{i_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_byte = 8'(i_ld_rdata >> {i_ld_addr_lo, 3'b000});
  assign w_half = i_ld_addr_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];

  always_comb begin
    o_ld_data = i_ld_rdata;
    case (i_ld_whb)
      WHB_BYTE: o_ld_data = {{24{i_ld_su & w_byte[7]}}, w_byte};
      WHB_HALF: o_ld_data = {{16{i_ld_su & w_half[15]}}, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store sequencer: accepts one op from EX/MEM, runs the memory
// handshake, and stalls the pipeline until the op completes or is rejected.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_rd,
  input  logic              ex_wr,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [1:0]        ex_whb,
  input  logic              ex_su,
  output logic              stall,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_data,
  output logic              lsu_err,
  output state_t            dbg_state,
  lsu_ctrl_if.master        mem
);

  state_t r_state, w_next;

  logic              w_accept, w_illegal;
  logic              r_wr, r_err, r_su;
  logic [1:0]        r_whb, r_addr_lo;
  logic [DATA_W-1:0] r_ld_data;
  logic              r_req, r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata, w_ld_ext;

  assign w_accept  = ex_valid & (ex_rd | ex_wr);
  assign w_illegal = (ex_rd & ex_wr) | ~whb_aligned(ex_whb, ex_addr[1:0]);

  lsu_align u_align (
    .i_st_whb     (ex_whb),
    .i_st_addr_lo (ex_addr[1:0]),
    .i_st_data    (ex_wdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .i_ld_whb     (r_whb),
    .i_ld_addr_lo (r_addr_lo),
    .i_ld_su      (r_su),
    .i_ld_rdata   (mem.mem_rdata),
    .o_ld_data    (w_ld_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)       w_next = w_illegal ? ST_DONE : ST_REQ;
      ST_REQ:  if (mem.mem_gnt)    w_next = r_wr ? ST_DONE : ST_WAIT;
      ST_WAIT: if (mem.mem_rvalid) w_next = ST_DONE;
      default:                     w_next = ST_IDLE;
    endcase
  end

  // The request drops once granted; the remaining mem_* fields hold until DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr      <= 1'b0;
      r_err     <= 1'b0;
      r_su      <= 1'b0;
      r_whb     <= 2'b00;
      r_addr_lo <= 2'b00;
      r_ld_data <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_be      <= 4'b0000;
      r_wdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_wr      <= ex_wr;
          r_err     <= w_illegal;
          r_su      <= ex_su;
          r_whb     <= ex_whb;
          r_addr_lo <= ex_addr[1:0];
          if (!w_illegal) begin
            r_req   <= 1'b1;
            r_we    <= ex_wr;
            r_addr  <= {ex_addr[ADDR_W-1:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
          end
        end
        ST_REQ: if (mem.mem_gnt) begin
          r_req <= 1'b0;
          if (r_wr) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= 4'b0000;
            r_wdata <= '0;
          end
        end
        ST_WAIT: if (mem.mem_rvalid) begin
          r_ld_data <= w_ld_ext;
          r_we      <= 1'b0;
          r_addr    <= '0;
          r_be      <= 4'b0000;
          r_wdata   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign stall = rst_n & (((r_state == ST_IDLE) & w_accept) |
                          (r_state == ST_REQ) | (r_state == ST_WAIT));
  assign ld_valid  = (r_state == ST_DONE) & ~r_wr & ~r_err;
  assign lsu_err   = (r_state == ST_DONE) & r_err;
  assign ld_data   = r_ld_data;
  assign dbg_state = r_state;

  assign mem.mem_req   = r_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_be    = r_be;
  assign mem.mem_wdata = r_wdata;

endmodule
